// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single shared memory port, one transaction outstanding at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_read_en,
    input  logic                  p0_write_en,
    input  logic [DATA_WIDTH-1:0] p0_write_val,
    output logic [DATA_WIDTH-1:0] p0_read_val,
    output logic                  p0_response,
    output logic                  p0_error,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_read_en,
    input  logic                  p1_write_en,
    input  logic [DATA_WIDTH-1:0] p1_write_val,
    output logic [DATA_WIDTH-1:0] p1_read_val,
    output logic                  p1_response,
    output logic                  p1_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_val,
    input  logic [DATA_WIDTH-1:0] mem_read_val,
    input  logic                  mem_response
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic        grant;
    logic [15:0] tmo_cnt;
    logic        req0, req1, pick, tmo_hit;

    assign req0    = p0_read_en | p0_write_en;
    assign req1    = p1_read_en | p1_write_en;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((tmo_cnt + 16'd1) == TMO_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        pick = ~req0;
        if (req0 && req1)
            pick = ~last_grant;
    end
`else
    always_comb begin
        pick = ~req0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            tmo_cnt       <= '0;
            p0_read_val   <= '0;
            p1_read_val   <= '0;
            p0_response   <= 1'b0;
            p1_response   <= 1'b0;
            p0_error      <= 1'b0;
            p1_error      <= 1'b0;
            mem_addr      <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            mem_write_val <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            p0_response <= 1'b0;
            p1_response <= 1'b0;
            p0_error    <= 1'b0;
            p1_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant   <= pick;
                        tmo_cnt <= '0;
                        state   <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= pick;
`endif
                        // write wins when a port raises both enables
                        if (pick) begin
                            mem_addr      <= p1_addr;
                            mem_write_val <= p1_write_val;
                            mem_write_en  <= p1_write_en;
                            mem_read_en   <= ~p1_write_en;
                        end else begin
                            mem_addr      <= p0_addr;
                            mem_write_val <= p0_write_val;
                            mem_write_en  <= p0_write_en;
                            mem_read_en   <= ~p0_write_en;
                        end
                    end
                end
                BUSY: begin
                    if (mem_response) begin
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        state        <= DONE;
                        if (grant) begin
                            p1_response <= 1'b1;
                            if (mem_read_en) p1_read_val <= mem_read_val;
                        end else begin
                            p0_response <= 1'b1;
                            if (mem_read_en) p0_read_val <= mem_read_val;
                        end
                    end else if (tmo_hit) begin
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        state        <= DONE;
                        if (grant) begin
                            p1_response <= 1'b1;
                            p1_error    <= 1'b1;
                        end else begin
                            p0_response <= 1'b1;
                            p0_error    <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized single transactions
// scored against a transaction-level expectation model.
module tb_memory_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] p0_addr, p1_addr, p0_write_val, p1_write_val;
    logic        p0_read_en, p0_write_en, p1_read_en, p1_write_en;
    logic [15:0] p0_read_val, p1_read_val;
    logic        p0_response, p1_response, p0_error, p1_error;
    logic [15:0] mem_addr, mem_write_val, mem_read_val;
    logic        mem_read_en, mem_write_en, mem_response;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_rv [2];

    int          ob_en, ob_resp, ob_err, ob_other, ob_rcyc;
    bit          ob_rd, ob_wr, ob_steady;
    logic [15:0] ob_addr, ob_wval;

    always #5 clk = ~clk;

    memory_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p0_read_en(p0_read_en), .p0_write_en(p0_write_en),
        .p0_write_val(p0_write_val), .p0_read_val(p0_read_val),
        .p0_response(p0_response), .p0_error(p0_error),
        .p1_addr(p1_addr), .p1_read_en(p1_read_en), .p1_write_en(p1_write_en),
        .p1_write_val(p1_write_val), .p1_read_val(p1_read_val),
        .p1_response(p1_response), .p1_error(p1_error),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
        .mem_response(mem_response)
    );

    // Runs one request on one port with a memory that answers after `lat` enable cycles
    // (lat=0: never). Records what was seen on the memory side and on both requester ports.
    task automatic do_txn(input int port, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wval, input logic [15:0] rval, input int lat,
                          input bit noise);
        logic rp, ep, ro, eo;
        ob_en = 0; ob_resp = 0; ob_err = 0; ob_other = 0; ob_rcyc = -1;
        ob_rd = 0; ob_wr = 0; ob_steady = 1; ob_addr = '0; ob_wval = '0;
        if (port == 0) begin
            p0_addr = addr; p0_write_val = wval; p0_read_en = rd; p0_write_en = wr;
        end else begin
            p1_addr = addr; p1_write_val = wval; p1_read_en = rd; p1_write_en = wr;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (mem_read_en || mem_write_en) begin
                if (ob_en == 0) begin
                    ob_addr = mem_addr; ob_wval = mem_write_val;
                end else if (mem_addr !== ob_addr || mem_write_val !== ob_wval) begin
                    ob_steady = 0;
                end
                ob_en++;
                ob_rd = ob_rd | mem_read_en;
                ob_wr = ob_wr | mem_write_en;
            end
            rp = (port == 0) ? p0_response : p1_response;
            ep = (port == 0) ? p0_error : p1_error;
            ro = (port == 0) ? p1_response : p0_response;
            eo = (port == 0) ? p1_error : p0_error;
            if (rp) begin
                ob_resp++;
                if (ep) ob_err++;
                if (ob_rcyc < 0) ob_rcyc = c;
            end
            if (ro || eo) ob_other++;
            mem_response = 1'b0;
            if ((mem_read_en || mem_write_en) && ob_en == lat) begin
                mem_response = 1'b1;
                mem_read_val = rval;
            end
            if (rp) begin
                p0_read_en = 0; p0_write_en = 0; p1_read_en = 0; p1_write_en = 0;
                mem_response = noise;
            end
            if (ob_rcyc > 0 && c == ob_rcyc + 1) mem_response = noise;
            if (ob_rcyc > 0 && c == ob_rcyc + 2) break;
        end
        mem_response = 1'b0;
        p0_read_en = 0; p0_write_en = 0; p1_read_en = 0; p1_write_en = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({p0_read_val, p1_read_val, mem_addr, mem_write_val} !== 64'd0) begin
            n_bad++; $display("FAIL reset_buses: got %h %h %h %h want all 0",
                              p0_read_val, p1_read_val, mem_addr, mem_write_val);
        end
        n_cmp++;
        if ({p0_response, p1_response, p0_error, p1_error, mem_read_en, mem_write_en} !== 6'd0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000",
                              {p0_response, p1_response, p0_error, p1_error, mem_read_en, mem_write_en});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rv[0] = '0; exp_rv[1] = '0;
    endtask

    task automatic test_write();
        do_txn(0, 0, 1, 16'd3, 16'd8, 16'd0, 2, 0);
        n_cmp++;
        if (ob_en !== 2) begin n_bad++; $display("FAIL write_en_cycles: got %0d want 2", ob_en); end
        n_cmp++;
        if ({ob_wr, ob_rd} !== 2'b10) begin n_bad++; $display("FAIL write_op: got wr=%0b rd=%0b want wr=1 rd=0", ob_wr, ob_rd); end
        n_cmp++;
        if (ob_addr !== 16'd3 || ob_wval !== 16'd8) begin
            n_bad++; $display("FAIL write_addr_val: got %0d/%0d want 3/8", ob_addr, ob_wval);
        end
        n_cmp++;
        if (ob_resp !== 1 || ob_rcyc !== 3) begin
            n_bad++; $display("FAIL write_response: got %0d pulses at %0d want 1 at 3", ob_resp, ob_rcyc);
        end
        n_cmp++;
        if (ob_other !== 0 || ob_err !== 0) begin
            n_bad++; $display("FAIL write_quiet: got other=%0d err=%0d want 0/0", ob_other, ob_err);
        end
    endtask

    task automatic test_read();
        do_txn(0, 1, 0, 16'd10, 16'd0, 16'h0055, 1, 0);
        exp_rv[0] = 16'h0055;
        n_cmp++;
        if (p0_read_val !== exp_rv[0] || ob_rcyc !== 2) begin
            n_bad++; $display("FAIL read_min_latency: got val=%h at %0d want %h at 2", p0_read_val, ob_rcyc, exp_rv[0]);
        end
        do_txn(1, 1, 0, 16'd3, 16'd0, 16'd8, 1, 0);
        exp_rv[1] = 16'd8;
        n_cmp++;
        if (p1_read_val !== 16'd8) begin n_bad++; $display("FAIL read_p1_val: got %0d want 8", p1_read_val); end
        n_cmp++;
        if (ob_resp !== 1 || ob_other !== 0) begin
            n_bad++; $display("FAIL read_p1_pulse: got %0d/%0d want 1/0", ob_resp, ob_other);
        end
        n_cmp++;
        if (p0_read_val !== exp_rv[0]) begin n_bad++; $display("FAIL read_p0_hold: got %h want %h", p0_read_val, exp_rv[0]); end
    endtask

    task automatic test_both_en();
        do_txn(0, 1, 1, 16'd5, 16'd9, 16'h0BAD, 1, 0);
        n_cmp++;
        if ({ob_wr, ob_rd} !== 2'b10 || ob_wval !== 16'd9 || ob_addr !== 16'd5) begin
            n_bad++; $display("FAIL both_en_write: got wr=%0b rd=%0b val=%0d addr=%0d want 1 0 9 5",
                              ob_wr, ob_rd, ob_wval, ob_addr);
        end
        n_cmp++;
        if (p0_read_val !== exp_rv[0]) begin n_bad++; $display("FAIL both_en_rv: got %h want %h", p0_read_val, exp_rv[0]); end
    endtask

    task automatic test_timeout();
        do_txn(0, 1, 0, 16'd1, 16'd0, 16'hDEAD, 0, 0);
        n_cmp++;
        if (ob_en !== TMO) begin n_bad++; $display("FAIL timeout_en_cycles: got %0d want %0d", ob_en, TMO); end
        n_cmp++;
        if (ob_resp !== 1 || ob_err !== 1 || ob_rcyc !== TMO + 1) begin
            n_bad++; $display("FAIL timeout_pulse: got resp=%0d err=%0d at %0d want 1 1 at %0d",
                              ob_resp, ob_err, ob_rcyc, TMO + 1);
        end
        n_cmp++;
        if (p0_read_val !== exp_rv[0]) begin n_bad++; $display("FAIL timeout_rv: got %h want %h", p0_read_val, exp_rv[0]); end
    endtask

    task automatic test_reset_busy();
        int pulses;
        pulses = 0;
        p0_addr = 16'd7; p0_write_val = 16'h1234; p0_write_en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_write_en !== 1'b1) begin n_bad++; $display("FAIL rstbusy_granted: got %b want 1", mem_write_en); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({mem_write_en, mem_read_en} !== 2'b00) begin
            n_bad++; $display("FAIL rstbusy_async_drop: got %b want 00", {mem_write_en, mem_read_en});
        end
        p0_write_en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (p0_response || p1_response || p0_error || p1_error) pulses++;
        end
        reset = 1'b0;
        exp_rv[0] = '0; exp_rv[1] = '0;
        repeat (2) begin
            @(posedge clk); #1;
            if (p0_response || p1_response || p0_error || p1_error) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_bad++; $display("FAIL rstbusy_no_pulse: got %0d want 0", pulses); end
        do_txn(1, 1, 0, 16'd4, 16'd0, 16'h0077, 2, 0);
        exp_rv[1] = 16'h0077;
        n_cmp++;
        if (ob_resp !== 1 || p1_read_val !== exp_rv[1] || p0_read_val !== 16'd0) begin
            n_bad++; $display("FAIL rstbusy_after: got resp=%0d rv1=%h rv0=%h want 1 %h 0",
                              ob_resp, p1_read_val, p0_read_val, exp_rv[1]);
        end
    endtask

    task automatic test_arbitration();
        int got[$];
        int want[$];
        int c0, last;
        bit w0, rr;
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        // Policy model: p0 wants service until it has had 3 grants, p1 always wants it.
        c0 = 0; last = 1;
        for (int g = 0; g < 5; g++) begin
            w0 = (c0 < 3);
            if (w0 && (!rr || last == 1)) begin want.push_back(0); c0++; last = 0; end
            else begin want.push_back(1); last = 1; end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rv[0] = '0; exp_rv[1] = '0;
        c0 = 0;
        mem_response = 1'b1;
        mem_read_val = 16'h00A5;
        p0_addr = 16'd20; p1_addr = 16'd21;
        p0_read_en = 1'b1; p1_read_en = 1'b1;
        for (int c = 0; c < 60 && got.size() < 5; c++) begin
            @(posedge clk); #1;
            if (p0_response && p1_response) begin
                got.push_back(9);
            end else if (p0_response) begin
                got.push_back(0); c0++; p0_read_en = 1'b0;
            end else if (p1_response) begin
                got.push_back(1); p1_read_en = 1'b0;
            end else begin
                p0_read_en = (c0 < 3); p1_read_en = 1'b1;
            end
        end
        mem_response = 1'b0;
        p0_read_en = 1'b0; p1_read_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_rv[0] = 16'h00A5; exp_rv[1] = 16'h00A5;
        n_cmp++;
        if (got.size() !== 5) begin n_bad++; $display("FAIL arb_count: got %0d grants want 5", got.size()); end
        for (int g = 0; g < 5 && g < got.size(); g++) begin
            n_cmp++;
            if (got[g] !== want[g]) begin n_bad++; $display("FAIL arb_grant[%0d]: got %0d want %0d", g, got[g], want[g]); end
        end
    endtask

    task automatic test_random();
        int port, op, lat, exp_en, exp_err;
        bit rd, wr, nz;
        logic [15:0] a, wv, rv;
        for (int t = 0; t < 40; t++) begin
            port = int'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(0, 4));
            if (lat == 4) lat = 6;
            nz   = 1'($urandom_range(0, 1));
            rd = (op != 1); wr = (op != 0);
            a = 16'($urandom); wv = 16'($urandom); rv = 16'($urandom);
            exp_err = (lat >= 1 && lat < TMO) ? 0 : 1;
            exp_en  = exp_err ? TMO : lat;
            if (rd && !wr && !exp_err) exp_rv[port] = rv;
            do_txn(port, rd, wr, a, wv, rv, lat, nz);
            n_cmp++;
            if (ob_en !== exp_en || ob_rcyc !== exp_en + 1) begin
                n_bad++; $display("FAIL rnd%0d_timing: got en=%0d resp_at=%0d want %0d %0d",
                                  t, ob_en, ob_rcyc, exp_en, exp_en + 1);
            end
            n_cmp++;
            if (ob_resp !== 1 || ob_err !== exp_err || ob_other !== 0) begin
                n_bad++; $display("FAIL rnd%0d_pulses: got resp=%0d err=%0d other=%0d want 1 %0d 0",
                                  t, ob_resp, ob_err, ob_other, exp_err);
            end
            n_cmp++;
            if (ob_addr !== a || ob_wval !== wv || !ob_steady || {ob_wr, ob_rd} !== {wr, !wr}) begin
                n_bad++; $display("FAIL rnd%0d_mem: got addr=%h val=%h steady=%0b wr=%0b rd=%0b want %h %h 1 %0b %0b",
                                  t, ob_addr, ob_wval, ob_steady, ob_wr, ob_rd, a, wv, wr, !wr);
            end
            n_cmp++;
            if (p0_read_val !== exp_rv[0] || p1_read_val !== exp_rv[1]) begin
                n_bad++; $display("FAIL rnd%0d_read_val: got %h %h want %h %h",
                                  t, p0_read_val, p1_read_val, exp_rv[0], exp_rv[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        p0_addr = '0; p1_addr = '0; p0_write_val = '0; p1_write_val = '0;
        p0_read_en = 0; p0_write_en = 0; p1_read_en = 0; p1_write_en = 0;
        mem_read_val = '0; mem_response = 0;
        test_reset();
        test_write();
        test_read();
        test_both_en();
        test_timeout();
        test_reset_busy();
        test_arbitration();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data buses.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum BUSY cycles without mem_response before abort; 0 disables the timeout; legal range 0..65535.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pN_addr (N=0,1)  input  ADDR_WIDTH  requester N address.
REQ-007 pN_read_en  input  1  requester N read request, level, held until pN_response.
REQ-008 pN_write_en  input  1  requester N write request, level, held until pN_response.
REQ-009 pN_write_val  input  DATA_WIDTH  requester N write data.
REQ-010 pN_read_val  output  DATA_WIDTH  requester N read data, registered.
REQ-011 pN_response  output  1  one-cycle completion pulse to requester N.
REQ-012 pN_error  output  1  one-cycle timeout flag, coincident with pN_response.
REQ-013 mem_addr  output  ADDR_WIDTH  shared memory address, registered.
REQ-014 mem_read_en / mem_write_en  output  1  shared memory read/write strobes, registered, level.
REQ-015 mem_write_val  output  DATA_WIDTH  shared memory write data, registered.
REQ-016 mem_read_val  input  DATA_WIDTH  shared memory read data, valid when mem_response=1.
REQ-017 mem_response  input  1  shared memory completion.

Function
REQ-018 Port N is requesting when pN_read_en|pN_write_en; when both are high, the write SHALL be performed and the read ignored.
REQ-019 States: IDLE, BUSY, DONE; at most one transaction is outstanding on the memory side.
REQ-020 IDLE: at a rising edge with >=1 request, the arbiter SHALL grant one port, latch its addr, write_val and op into mem_addr, mem_write_val and the matching mem_*_en, and enter BUSY; with no request, it remains in IDLE with both mem_*_en low.
REQ-021 BUSY: mem_addr, mem_write_val and the enable SHALL stay constant until the edge that samples mem_response=1.
- On that edge: enable cleared, pN_read_val<=mem_read_val (reads only), pN_response=1 for the following cycle, state->DONE.
REQ-022 Latency: request sampled at edge t -> mem enable high after t -> pN_response high the cycle after mem_response is sampled; the minimum request-to-response latency is 2 cycles.
REQ-023 DONE lasts exactly one cycle with both mem_*_en low, then the arbiter SHALL return to IDLE; requesters deassert enables during DONE.
REQ-024 Timeout: a 16-bit counter SHALL clear on BUSY entry and increment each BUSY cycle.
- With TIMEOUT_CYCLES>0 and the count reaching TIMEOUT_CYCLES: enable cleared, pN_response=1 and pN_error=1 for one cycle, pN_read_val unchanged, state->DONE.
REQ-025 Request withdrawn during BUSY: the transaction SHALL still complete, and pN_response SHALL still pulse.
REQ-026 mem_response while IDLE or DONE SHALL be ignored.
REQ-027 The non-granted port's response and error outputs SHALL stay 0; pN_read_val SHALL hold until the next completed read on port N (writes and timeouts do not alter it).

Reset
REQ-028 While reset=1, asynchronously: state=IDLE, all outputs 0 (read_val, response, error, mem_*), timeout counter=0, last_grant=1.
REQ-029 Reset mid-BUSY SHALL drop mem_*_en immediately, abort the transaction, and emit no response pulse.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the grant SHALL go to the port not granted last (last_grant register, updated on each grant); port 0 wins first after reset.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins ties; last_grant is not implemented.

Verification
REQ-032 p0 write addr=3 val=8, memory responds 2 cycles later -> mem_write_en high 2 cycles, mem_addr=3, mem_write_val=8, one p0_response pulse, p1 outputs 0.
REQ-033 p1 read addr=3, mem_read_val=8 with mem_response -> p1_read_val=8, single p1_response pulse, p0_read_val unchanged.
REQ-034 p0 and p1 both request continuously, zero-wait memory -> with ARB_ROUND_ROBIN_EN: grants 0,1,0,1; without it: p1 is served only after p0 drops its request.
REQ-035 TIMEOUT_CYCLES=4, mem_response held 0 -> enable drops after 4 BUSY cycles, p0_response=p0_error=1 for one cycle, p0_read_val unchanged.
REQ-036 reset asserted in BUSY between edges -> mem_*_en falls without a clock edge, no response pulse; after release, a new p1 request is served normally.
REQ-037 p0_read_en and p0_write_en both high, addr=5, val=9 -> only mem_write_en asserted, with mem_write_val=9.
